// File: rtl/maf_pkg.sv
// -----------------------------------------------------------------------------
// maf_pkg
// Shared definitions for the moving-average filter and its level detector:
// the detector state encoding, the filter sum width, and the default
// thresholds / hold count that the filter bench reuses.
// No ports (package).
// -----------------------------------------------------------------------------
package maf_pkg;

    localparam int MAF_SUM_W = 8;

    localparam logic [MAF_SUM_W-1:0] MAF_HI_TH_DEF = 8'd80;
    localparam logic [MAF_SUM_W-1:0] MAF_LO_TH_DEF = 8'd40;
    localparam int                   MAF_HOLD_DEF  = 4;

    // LOW/ARM_HI report level 0, HIGH/ARM_LO report level 1.
    typedef enum logic [1:0] {
        LOW    = 2'd0,
        ARM_HI = 2'd1,
        HIGH   = 2'd2,
        ARM_LO = 2'd3
    } maf_state_e;

endpackage

// File: rtl/maf_level_det_if.sv
// -----------------------------------------------------------------------------
// maf_level_det_if
// Bundles the filtered-sum input and the detector outputs.
//   din      filtered sum from the moving-average filter (unsigned)
//   level    debounced level
//   rise     one-cycle pulse when level goes 0->1
//   fall     one-cycle pulse when level goes 1->0
//   evt_cnt  saturating count of rise events
// Modports: master = upstream filter side (drives din),
//           slave  = the level detector (drives the results).
// -----------------------------------------------------------------------------
interface maf_level_det_if;
    import maf_pkg::*;

    logic [MAF_SUM_W-1:0] din;
    logic                 level;
    logic                 rise;
    logic                 fall;
    logic [7:0]           evt_cnt;

    modport master (output din, input level, rise, fall, evt_cnt);
    modport slave  (input din, output level, rise, fall, evt_cnt);

endinterface

// File: rtl/maf_qual_cnt.sv
// -----------------------------------------------------------------------------
// maf_qual_cnt
// Qualification counter shared by both arm states of the level detector.
// Counts consecutive qualifying samples and flags the sample that would
// complete a transition.
//   clk    clock
//   reset  synchronous, active-high
//   clr    clear count to 0 (wins over inc)
//   inc    increment count
//   qcnt   current count of qualifying samples already seen
//   tc     current sample, if qualifying, is the HOLD-th one
// -----------------------------------------------------------------------------
module maf_qual_cnt #(
    parameter int HOLD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] qcnt,
    output logic       tc
);

    // Widened by one bit so qcnt+1 cannot wrap before the compare.
    assign tc = (({1'b0, qcnt} + 5'd1) == 5'(HOLD));

    always_ff @(posedge clk) begin
        if (reset) begin
            qcnt <= 4'd0;
        end else if (clr) begin
            qcnt <= 4'd0;
        end else if (inc) begin
            qcnt <= qcnt + 4'd1;
        end
    end

endmodule

// File: rtl/maf_level_det.sv
// -----------------------------------------------------------------------------
// maf_level_det
// Hysteresis level detector behind the moving-average filter. A transition is
// declared once din stays beyond the relevant threshold for HOLD consecutive
// samples; rise/fall pulse for one cycle as the level changes.
//   clk    clock
//   reset  synchronous, active-high
//   bus    maf_level_det_if.slave: din in; level, rise, fall, evt_cnt out
// Optional feature: define MAF_LEVEL_EVT_CNT_EN to build the saturating rise
// event counter; otherwise evt_cnt is tied to 0.
// -----------------------------------------------------------------------------
module maf_level_det
    import maf_pkg::*;
#(
    parameter logic [MAF_SUM_W-1:0] HI_TH = MAF_HI_TH_DEF,
    parameter logic [MAF_SUM_W-1:0] LO_TH = MAF_LO_TH_DEF,
    parameter int                   HOLD  = MAF_HOLD_DEF
) (
    input  logic               clk,
    input  logic               reset,
    maf_level_det_if.slave     bus
);

    maf_state_e state;
    maf_state_e state_nxt;
    logic       qual;
    logic       tc;
    logic       clr;
    logic       inc;
    logic       rise_nxt;
    logic       fall_nxt;
    logic       rise_q;
    logic       fall_q;
    logic [3:0] qcnt;

    // qcnt is 0 whenever the FSM sits in LOW or HIGH, so the same terminal
    // compare also covers HOLD==1 (transition on the first qualifying sample).
    maf_qual_cnt #(.HOLD(HOLD)) u_qual (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .inc   (inc),
        .qcnt  (qcnt),
        .tc    (tc)
    );

    // Qualifying direction depends only on the current level side.
    always_comb begin
        qual = 1'b0;
        case (state)
            LOW, ARM_HI: qual = (bus.din >= HI_TH);
            HIGH, ARM_LO: qual = (bus.din < LO_TH);
            default: qual = 1'b0;
        endcase
    end

    // State register; rise/fall are registered so no din->output path exists.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= LOW;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            rise_q <= rise_nxt;
            fall_q <= fall_nxt;
        end
    end

    // Next state and counter control.
    always_comb begin
        state_nxt = state;
        clr       = 1'b1;
        inc       = 1'b0;
        case (state)
            LOW, ARM_HI: begin
                if (qual && tc) begin
                    state_nxt = HIGH;
                end else if (qual) begin
                    state_nxt = ARM_HI;
                    clr       = 1'b0;
                    inc       = 1'b1;
                end else begin
                    state_nxt = LOW;
                end
            end
            HIGH, ARM_LO: begin
                if (qual && tc) begin
                    state_nxt = LOW;
                end else if (qual) begin
                    state_nxt = ARM_LO;
                    clr       = 1'b0;
                    inc       = 1'b1;
                end else begin
                    state_nxt = HIGH;
                end
            end
            default: state_nxt = LOW;
        endcase
    end

    // Outputs: event pulses are decided here and captured on the next edge.
    always_comb begin
        rise_nxt = 1'b0;
        fall_nxt = 1'b0;
        case (state)
            LOW, ARM_HI: rise_nxt = qual && tc;
            HIGH, ARM_LO: fall_nxt = qual && tc;
            default: ;
        endcase
    end

    assign bus.level = (state == HIGH) || (state == ARM_LO);
    assign bus.rise  = rise_q;
    assign bus.fall  = fall_q;

`ifdef MAF_LEVEL_EVT_CNT_EN
    logic [7:0] evt_cnt_q;

    // Counts on the same edge that sets rise; holds at 255.
    always_ff @(posedge clk) begin
        if (reset) begin
            evt_cnt_q <= 8'd0;
        end else if (rise_nxt && (evt_cnt_q != 8'd255)) begin
            evt_cnt_q <= evt_cnt_q + 8'd1;
        end
    end

    assign bus.evt_cnt = evt_cnt_q;
`else
    assign bus.evt_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_maf_level_det.sv
// -----------------------------------------------------------------------------
// tb_maf_level_det
// Self-checking bench for maf_level_det with default parameters
// (HI_TH=80, LO_TH=40, HOLD=4). A level/run-length model is compared against
// the DUT on every falling edge, and directed sequences carry hand-computed
// expectations.
// -----------------------------------------------------------------------------
module tb_maf_level_det;

    localparam logic [7:0] HI   = 8'd80;
    localparam logic [7:0] LO   = 8'd40;
    localparam int         HOLD = 4;
`ifdef MAF_LEVEL_EVT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    maf_level_det_if bus ();

    maf_level_det dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Model: current level plus length of the current run of samples that
    // argue for leaving it.
    bit       m_valid = 1'b0;
    bit       m_level;
    bit       m_rise;
    bit       m_fall;
    int       m_run;
    int       m_evt;

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1'b1;
            m_level = 1'b0;
            m_rise  = 1'b0;
            m_fall  = 1'b0;
            m_run   = 0;
            m_evt   = 0;
        end else if (m_valid) begin
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (m_level ? (bus.din < LO) : (bus.din >= HI)) begin
                m_run++;
                if (m_run == HOLD) begin
                    m_level = !m_level;
                    m_rise  = m_level;
                    m_fall  = !m_level;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
            if (m_rise && CNT_EN && (m_evt < 255)) m_evt++;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_level", bus.level, m_level);
            chk("model_rise", bus.rise, m_rise);
            chk("model_fall", bus.fall, m_fall);
            chk("model_evt_cnt", bus.evt_cnt, m_evt);
            chk("rise_fall_excl", bus.rise & bus.fall, 0);
        end
    end

    int rises;
    int falls;

    task automatic step(input logic [7:0] d, input logic r);
        reset   = r;
        bus.din = d;
        @(posedge clk);
        @(negedge clk);
        if (bus.rise === 1'b1) rises++;
        if (bus.fall === 1'b1) falls++;
    endtask

    initial begin
        reset   = 1'b1;
        bus.din = 8'd200;
        @(negedge clk);

        // Reset with a strongly qualifying input.
        step(8'd200, 1'b1);
        chk("rst_level", bus.level, 0);
        chk("rst_rise", bus.rise, 0);
        chk("rst_fall", bus.fall, 0);
        chk("rst_evt", bus.evt_cnt, 0);
        step(8'd200, 1'b1);
        chk("rst_hold_level", bus.level, 0);

        // Clean rise.
        for (int i = 0; i < 3; i++) begin
            step(8'd100, 1'b0);
            chk("clean_pre_level", bus.level, 0);
            chk("clean_pre_rise", bus.rise, 0);
        end
        step(8'd100, 1'b0);
        chk("clean_level", bus.level, 1);
        chk("clean_rise", bus.rise, 1);
        chk("clean_evt", bus.evt_cnt, CNT_EN ? 1 : 0);
        step(8'd100, 1'b0);
        chk("clean_rise_width", bus.rise, 0);
        chk("clean_level_hold", bus.level, 1);

        // Back to LOW.
        for (int i = 0; i < 3; i++) step(8'd0, 1'b0);
        step(8'd0, 1'b0);
        chk("ret_fall", bus.fall, 1);
        chk("ret_level", bus.level, 0);

        // Glitch rejection; 80 is on the threshold and qualifies.
        rises = 0;
        step(8'd100, 1'b0);
        step(8'd100, 1'b0);
        step(8'd100, 1'b0);
        step(8'd79, 1'b0);
        step(8'd80, 1'b0);
        step(8'd100, 1'b0);
        step(8'd100, 1'b0);
        chk("glitch_no_rise", rises, 0);
        chk("glitch_level", bus.level, 0);
        step(8'd80, 1'b0);
        chk("glitch_rise", bus.rise, 1);
        chk("glitch_rise_count", rises, 1);

        // Hysteresis: values at or above LO_TH never start a fall.
        falls = 0;
        for (int i = 0; i < 20; i++) step(8'd60, 1'b0);
        for (int i = 0; i < 4; i++) step(8'd40, 1'b0);
        chk("hyst_level", bus.level, 1);
        chk("hyst_no_fall", falls, 0);
        for (int i = 0; i < 3; i++) step(8'd39, 1'b0);
        chk("hyst_pre_fall", bus.level, 1);
        step(8'd39, 1'b0);
        chk("hyst_fall", bus.fall, 1);
        chk("hyst_level_low", bus.level, 0);

        // Reset in the middle of an arm sequence.
        rises = 0;
        for (int i = 0; i < 3; i++) step(8'd100, 1'b0);
        step(8'd100, 1'b1);
        chk("midrst_level", bus.level, 0);
        chk("midrst_rise", bus.rise, 0);
        chk("midrst_evt", bus.evt_cnt, 0);
        for (int i = 0; i < 3; i++) step(8'd100, 1'b0);
        chk("midrst_no_rise", rises, 0);
        step(8'd100, 1'b0);
        chk("midrst_rise_after", bus.rise, 1);
        chk("midrst_evt_after", bus.evt_cnt, CNT_EN ? 1 : 0);
        for (int i = 0; i < 4; i++) step(8'd0, 1'b0);

        // Saturation of the event counter.
        rises = 0;
        for (int n = 0; n < 260; n++) begin
            for (int i = 0; i < 4; i++) step(8'd100, 1'b0);
            for (int i = 0; i < 4; i++) step(8'd0, 1'b0);
        end
        chk("sat_rises", rises, 260);
        chk("sat_evt", bus.evt_cnt, CNT_EN ? 255 : 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/maf_level_det.md
# maf_level_det

Hysteresis level detector sitting directly downstream of the moving-average filter: consumes its 8-bit windowed sum every clock and converts it into a debounced binary level with one-cycle rise/fall event pulses. A transition is declared only after the sum stays beyond the relevant threshold for HOLD consecutive samples. An optional saturating counter tallies rising events for the host.

## Interface

Parameters:
- HI_TH, 8'd80, rise threshold; a sample qualifies for rising when din >= HI_TH
- LO_TH, 8'd40, fall threshold; a sample qualifies for falling when din < LO_TH; must satisfy LO_TH < HI_TH
- HOLD, 4, consecutive qualifying samples required per transition; legal range 1..15

Ports:
- clk  input  1  single clock; all state updates on posedge
- reset  input  1  synchronous, active-high; sampled on posedge clk
- din  input  8  filtered sum from the moving-average filter, unsigned, sampled every cycle
- level  output  1  debounced level, registered
- rise  output  1  one-cycle pulse on the edge level goes 0->1
- fall  output  1  one-cycle pulse on the edge level goes 1->0
- evt_cnt  output  8  saturating count of rise events (see Configuration)

## Operation

- FSM states: LOW, ARM_HI, HIGH, ARM_LO; qualification counter qcnt, 4 bits.
- LOW: din >= HI_TH -> if HOLD==1 go HIGH directly (rise), else ARM_HI with qcnt=1; otherwise stay, qcnt=0.
- ARM_HI: din >= HI_TH -> qcnt+1; when qcnt+1 == HOLD go HIGH, assert rise, clear qcnt. din < HI_TH -> back to LOW, qcnt=0 (glitch rejected, no output change).
- HIGH: din < LO_TH -> ARM_LO with qcnt=1 (or LOW directly with fall when HOLD==1); LO_TH <= din stays HIGH regardless of duration.
- ARM_LO: symmetric to ARM_HI using din < LO_TH; success -> LOW, assert fall; a non-qualifying sample -> back to HIGH, qcnt=0.
- level = 1 in HIGH and ARM_LO, 0 in LOW and ARM_HI.
- rise and fall never assert in the same cycle; each is exactly one cycle wide.
- Comparisons unsigned, full 8 bits; no arithmetic on din.

## Timing

- Reset: state LOW, qcnt=0, level=0, rise=0, fall=0, evt_cnt=0 on the first posedge with reset high; reset overrides all other activity including a transition completing in that cycle.
- Latency: the HOLD-th consecutive qualifying sample is captured at posedge N; level, rise/fall and evt_cnt reflect it after posedge N (visible in cycle N+1). No combinational path din -> outputs.
- Reset mid-ARM: pending qualification discarded, no pulse emitted.
- din exactly HI_TH qualifies for rise; din exactly LO_TH does not qualify for fall.

## Configuration

- MAF_LEVEL_EVT_CNT_EN defined: evt_cnt increments by 1 in the same cycle rise asserts, saturates at 8'd255, cleared only by reset.
- Not defined: counter register not instantiated; evt_cnt tied to 8'd0; all other behaviour identical.

## Structure

- Shared package maf_pkg: state enum (LOW, ARM_HI, HIGH, ARM_LO), MAF_SUM_W = 8 constant, default threshold/HOLD constants reused by the filter bench.
- One natural sub-module: maf_qual_cnt (qcnt with clear/increment and terminal-count compare against HOLD), instantiated once and shared by both arm states.

## Test plan

- Reset: drive reset with din=8'd200 -> level=0, rise=0, fall=0, evt_cnt=0 after one posedge; remains LOW while reset held.
- Clean rise (HI_TH=80, HOLD=4): din=100 for 4 cycles -> level and rise=1 after 4th edge only, rise low next cycle, evt_cnt=1.
- Glitch rejection: din=100 x3, 79 x1, 100 x4 -> no rise until final 4th 100; exactly one rise; din=80 counts as qualifying.
- Hysteresis: in HIGH, din=60 for 20 cycles, then din=40 for 4 cycles -> level stays 1; then din=39 x4 -> fall after 4th edge, level=0.
- Saturation: 260 complete rise/fall cycles -> evt_cnt=255 with MAF_LEVEL_EVT_CNT_EN, 0 without.
- Reset mid-operation: din=100 x3 then reset for 1 cycle then din=100 x3 -> no rise; one more 100 -> rise.
